// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed scan of NUM_DIGITS common-anode 7-segment digits through one external hex decoder.
// Latency : segment/anode pins follow the internal state/idx by one registered cycle; o_seg and o_an always aligned.
// Backpres: o_wr_ready = ~pending; a word offered while a frame-boundary update is still pending is held off until the wrap.
//
// Ports
//   i_clk, i_reset     single rising-edge clock, synchronous active-high reset
//   i_enable           1: scan digits, 0: display dark (counters and idx cleared)
//   i_wr_valid/o_wr_ready/i_wr_data
//                      display word handshake; nibble k drives digit k (digit 0 rightmost)
//   o_nibble           nibble presented to the external hex->7seg decoder (combinational)
//   i_hexcode          decoder result, active-low, bit6..0 = a..g
//   o_seg, o_an        registered active-low segment and one-cold anode drive
//   o_frame_tick       1-cycle pulse after the last digit's slot (frame wrap)

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 8,
  parameter int BLANK_LZ     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [4*NUM_DIGITS-1:0] i_wr_data,
  output logic [3:0]              o_nibble,
  input  logic [6:0]              i_hexcode,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_tick
);

  // ---------------------------------------------------------------------------
  // Counter widths. GUARD_CYCLES may be 1, which would give a zero-width
  // counter, so it is clamped to one bit.
  // ---------------------------------------------------------------------------
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [IW-1:0] idx_last   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] dwell_last = DW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] guard_last = GW'(GUARD_CYCLES - 1);

  localparam logic [6:0] seg_dark = 7'h7F;

  typedef enum logic [1:0] {
    st_off,
    st_scan,
    st_guard
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pend_buf_q, pend_buf_d;
  logic                    pending_q, pending_d;

  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic                    tick_d;

  // ---------------------------------------------------------------------------
  // Handshake and decoder feed
  // ---------------------------------------------------------------------------
  logic wr_fire;

  assign o_wr_ready = ~pending_q;
  assign wr_fire    = i_wr_valid & ~pending_q;
  assign o_nibble   = shadow_q[4*idx_q +: 4];

  // ---------------------------------------------------------------------------
  // Leading-zero detection: zero_from[k] is set when nibbles k..NUM_DIGITS-1
  // of the displayed word are all zero. Built from the top digit downwards
  // with a running accumulator.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;

  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc & (shadow_q[4*k +: 4] == 4'h0);
      zero_from[k] = zero_acc;
    end
  end

  // Digit 0 is never blanked so a zero word still shows a single "0".
  logic blank;
  assign blank = (BLANK_LZ != 0) && (idx_q != '0) && zero_from[idx_q];

  // ---------------------------------------------------------------------------
  // Slot bookkeeping
  // ---------------------------------------------------------------------------
  logic last_dwell;
  logic last_guard;
  logic frame_wrap;

  assign last_dwell = (dwell_q == dwell_last);
  assign last_guard = (guard_q == guard_last);
  assign frame_wrap = (state_q == st_guard) && last_guard && (idx_q == idx_last);

  // ---------------------------------------------------------------------------
  // Next-state, next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    guard_d    = guard_q;
    shadow_d   = shadow_q;
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    seg_d      = seg_dark;
    an_d       = '1;
    tick_d     = 1'b0;

    if (!i_enable) begin
      // Going dark from any state. A word still waiting for a frame boundary
      // is promoted now, since there is no frame to tear; a word arriving on
      // this very edge is newer and wins.
      state_d   = st_off;
      idx_d     = '0;
      dwell_d   = '0;
      guard_d   = '0;
      pending_d = 1'b0;
      if (wr_fire) begin
        shadow_d = i_wr_data;
      end else if (pending_q) begin
        shadow_d = pend_buf_q;
      end
    end else begin
      case (state_q)
        st_off: begin
          // Nothing is on the glass, so a new word can go straight to shadow.
          state_d = st_scan;
          idx_d   = '0;
          dwell_d = '0;
          guard_d = '0;
          if (wr_fire) begin
            shadow_d = i_wr_data;
          end
        end

        st_scan: begin
          // A blanked digit keeps its slot length so brightness stays uniform.
          if (!blank) begin
            seg_d = i_hexcode;
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
          end
          if (last_dwell) begin
            state_d = st_guard;
            guard_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
          if (wr_fire) begin
            pend_buf_d = i_wr_data;
            pending_d  = 1'b1;
          end
        end

        st_guard: begin
          if (last_guard) begin
            state_d = st_scan;
            dwell_d = '0;
            idx_d   = (idx_q == idx_last) ? '0 : idx_q + 1'b1;
          end else begin
            guard_d = guard_q + 1'b1;
          end
          // Frame boundary: the only point where a buffered word becomes
          // visible while scanning, so every frame shows a single word.
          if (frame_wrap) begin
            tick_d = 1'b1;
            if (pending_q) begin
              shadow_d  = pend_buf_q;
              pending_d = 1'b0;
            end
          end
          // wr_fire implies pending_q was clear, so this never collides with
          // the promotion above.
          if (wr_fire) begin
            pend_buf_d = i_wr_data;
            pending_d  = 1'b1;
          end
        end

        default: begin
          state_d = st_off;
          idx_d   = '0;
          dwell_d = '0;
          guard_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= st_off;
      idx_q        <= '0;
      dwell_q      <= '0;
      guard_q      <= '0;
      shadow_q     <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      o_seg        <= seg_dark;
      o_an         <= '1;
      o_frame_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dwell_q      <= dwell_d;
      guard_q      <= guard_d;
      shadow_q     <= shadow_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      o_seg        <= seg_d;
      o_an         <= an_d;
      o_frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose : directed self-checking bench for seg7_scan_ctrl with an attached hex->7seg decoder model.
// Latency : outputs sampled on the falling edge, one registered cycle after the state that produced them.
// Backpres: write offers are held by the bench while o_wr_ready is low.

module tb_seg7_scan_ctrl;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] DARK  = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  nibble;
  logic [6:0]  hexcode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Hex -> 7-segment decoder, active-low, bit6..0 = a..g.
  always_comb begin
    hexcode = 7'h7F;
    case (nibble)
      4'h0: hexcode = 7'b0000001;
      4'h1: hexcode = 7'b1001111;
      4'h2: hexcode = 7'b0010010;
      4'h3: hexcode = 7'b0000110;
      4'h4: hexcode = 7'b1001100;
      4'h5: hexcode = 7'b0100100;
      4'h6: hexcode = 7'b0100000;
      4'h7: hexcode = 7'b0001111;
      4'h8: hexcode = 7'b0000000;
      4'h9: hexcode = 7'b0000100;
      4'hA: hexcode = 7'b0001000;
      4'hB: hexcode = 7'b1100000;
      4'hC: hexcode = 7'b0110001;
      4'hD: hexcode = 7'b1000010;
      4'hE: hexcode = 7'b0110000;
      4'hF: hexcode = 7'b0111000;
      default: hexcode = 7'h7F;
    endcase
  end

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1),
    .BLANK_LZ    (1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_data   (wr_data),
    .o_nibble    (nibble),
    .i_hexcode   (hexcode),
    .o_seg       (seg),
    .o_an        (an),
    .o_frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic rdy_e);
    cyc();
    chk({tag, "_an"},   16'(an),         16'(an_e));
    chk({tag, "_seg"},  16'(seg),        16'(seg_e));
    chk({tag, "_rdy"},  16'(wr_ready),   16'(rdy_e));
    chk({tag, "_tick"}, 16'(frame_tick), 16'(1'b0));
  endtask

  task automatic dark(input string tag, input logic rdy_e, input logic tick_e);
    cyc();
    chk({tag, "_gan"},   16'(an),         16'(4'b1111));
    chk({tag, "_gseg"},  16'(seg),        16'(DARK));
    chk({tag, "_grdy"},  16'(wr_ready),   16'(rdy_e));
    chk({tag, "_gtick"}, 16'(frame_tick), 16'(tick_e));
  endtask

  // One digit slot: four lit cycles followed by one guard cycle.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic rdy_lit, input logic rdy_dark, input logic tick_e);
    for (int i = 0; i < 4; i++) lit(tag, an_e, seg_e, rdy_lit);
    dark(tag, rdy_dark, tick_e);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_an",   16'(an),         16'(4'b1111));
    chk("rst_seg",  16'(seg),        16'(DARK));
    chk("rst_rdy",  16'(wr_ready),   16'(1'b1));
    chk("rst_tick", 16'(frame_tick), 16'(1'b0));
    chk("rst_nib",  16'(nibble),     16'(4'h0));

    // 1. Direct load in OFF, then a full frame of 1234
    rst      = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    cyc();
    wr_valid = 1'b0;
    chk("off_nib", 16'(nibble), 16'(4'h4));
    chk("off_an",  16'(an),     16'(4'b1111));
    chk("off_rdy", 16'(wr_ready), 16'(1'b1));
    en = 1'b1;
    dark("start", 1'b1, 1'b0);
    slot("f1d0", 4'b1110, SEG_4, 1'b1, 1'b1, 1'b0);
    slot("f1d1", 4'b1101, SEG_3, 1'b1, 1'b1, 1'b0);
    slot("f1d2", 4'b1011, SEG_2, 1'b1, 1'b1, 1'b0);
    slot("f1d3", 4'b0111, SEG_1, 1'b1, 1'b1, 1'b1);

    // 3/4. Mid-scan write of ABCD, then FFFF held while pending
    chk("pre_abcd_rdy", 16'(wr_ready), 16'(1'b1));
    wr_valid = 1'b1;
    wr_data  = 16'hABCD;
    lit("f2d0", 4'b1110, SEG_4, 1'b0);
    wr_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) lit("f2d0", 4'b1110, SEG_4, 1'b0);
    dark("f2d0", 1'b0, 1'b0);
    slot("f2d1", 4'b1101, SEG_3, 1'b0, 1'b0, 1'b0);
    slot("f2d2", 4'b1011, SEG_2, 1'b0, 1'b0, 1'b0);
    slot("f2d3", 4'b0111, SEG_1, 1'b0, 1'b1, 1'b1);
    // FFFF is taken on the first cycle after the wrap
    lit("f3d0", 4'b1110, SEG_D, 1'b0);
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) lit("f3d0", 4'b1110, SEG_D, 1'b0);
    dark("f3d0", 1'b0, 1'b0);
    slot("f3d1", 4'b1101, SEG_C, 1'b0, 1'b0, 1'b0);
    slot("f3d2", 4'b1011, SEG_B, 1'b0, 1'b0, 1'b0);
    slot("f3d3", 4'b0111, SEG_A, 1'b0, 1'b1, 1'b1);
    slot("f4d0", 4'b1110, SEG_F, 1'b1, 1'b1, 1'b0);
    slot("f4d1", 4'b1101, SEG_F, 1'b1, 1'b1, 1'b0);

    // 5. Drop enable during digit 2 dwell
    lit("f4d2", 4'b1011, SEG_F, 1'b1);
    lit("f4d2", 4'b1011, SEG_F, 1'b1);
    en = 1'b0;
    cyc();
    chk("dis_an",  16'(an),  16'(4'b1111));
    chk("dis_seg", 16'(seg), 16'(DARK));

    // 2. Leading-zero blanking with 0070, loaded while dark
    wr_valid = 1'b1;
    wr_data  = 16'h0070;
    cyc();
    wr_valid = 1'b0;
    chk("lz_nib", 16'(nibble), 16'(4'h0));
    chk("lz_an",  16'(an),     16'(4'b1111));
    en = 1'b1;
    dark("restart", 1'b1, 1'b0);
    slot("lzd0", 4'b1110, SEG_0, 1'b1, 1'b1, 1'b0);
    slot("lzd1", 4'b1101, SEG_7, 1'b1, 1'b1, 1'b0);
    slot("lzd2", 4'b1111, DARK,  1'b1, 1'b1, 1'b0);
    slot("lzd3", 4'b1111, DARK,  1'b1, 1'b1, 1'b1);

    // 6. Reset in GUARD with a pending word
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    lit("rsd0", 4'b1110, SEG_0, 1'b0);
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) lit("rsd0", 4'b1110, SEG_0, 1'b0);
    chk("guard_pend_rdy", 16'(wr_ready), 16'(1'b0));
    rst = 1'b1;
    cyc();
    chk("rst2_an",   16'(an),         16'(4'b1111));
    chk("rst2_seg",  16'(seg),        16'(DARK));
    chk("rst2_rdy",  16'(wr_ready),   16'(1'b1));
    chk("rst2_tick", 16'(frame_tick), 16'(1'b0));
    chk("rst2_nib",  16'(nibble),     16'(4'h0));
    rst = 1'b0;
    dark("postrst", 1'b1, 1'b0);
    slot("prd0", 4'b1110, SEG_0, 1'b1, 1'b1, 1'b0);
    slot("prd1", 4'b1111, DARK,  1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
